// File: rtl/ff_pkg.sv
// Mode encodings and widths shared by the multimode flip-flop register and its bit cell.
package ff_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_D    = 3'b001;
    localparam logic [MODE_W-1:0] MODE_T    = 3'b010;
    localparam logic [MODE_W-1:0] MODE_JK   = 3'b011;
    localparam logic [MODE_W-1:0] MODE_SR   = 3'b100;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_ROTL = 3'b111;

endpackage

// File: rtl/multimode_ff_cell.sv
// One register bit acting as D/T/JK/SR flip-flop or shift/rotate stage.
module multimode_ff_cell
    import ff_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic              a,
    input  logic              b,
    input  logic              lo_in,
    input  logic              hi_in,
    output logic              next_c,
    output logic              conflict_c,
    output logic              q,
    output logic              conflict
);

    // Next-state selection; S=R=1 resolves to hold so the bit never goes X.
    always_comb begin
        next_c     = q;
        conflict_c = 1'b0;
        if (en) begin
            case (mode)
                MODE_D:    next_c = a;
                MODE_T:    next_c = q ^ a;
                MODE_JK: begin
                    case ({a, b})
                        2'b01:   next_c = 1'b0;
                        2'b10:   next_c = 1'b1;
                        2'b11:   next_c = ~q;
                        default: next_c = q;
                    endcase
                end
                MODE_SR: begin
                    conflict_c = a & b;
                    case ({a, b})
                        2'b01:   next_c = 1'b0;
                        2'b10:   next_c = 1'b1;
                        default: next_c = q;
                    endcase
                end
                MODE_SHL:  next_c = lo_in;
                MODE_ROTL: next_c = lo_in;
                MODE_SHR:  next_c = hi_in;
                default:   next_c = q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= RST_BIT;
            conflict <= 1'b0;
        end else begin
            q        <= next_c;
            conflict <= conflict_c;
        end
    end

endmodule

// File: rtl/multimode_ff_reg.sv
// WIDTH-bit multimode register: per-bit flip-flop cells plus serial output and sticky SR error.
module multimode_ff_reg
    import ff_pkg::*;
#(
    parameter int unsigned       WIDTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              ser_in,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  q,
    output logic              ser_out,
    output logic [WIDTH-1:0]  sr_conflict,
    output logic              sr_err
);

    logic [WIDTH-1:0] lo_c;
    logic [WIDTH-1:0] hi_c;
    logic [WIDTH-1:0] next_c;
    logic [WIDTH-1:0] conflict_c;
    logic             lo0_c;

    // Bit 0 is fed by ser_in when shifting and by the MSB when rotating.
    assign lo0_c = (mode == MODE_ROTL) ? q[WIDTH-1] : ser_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lo_edge
            assign lo_c[i] = lo0_c;
        end else begin : g_lo_mid
            assign lo_c[i] = q[i-1];
        end

        if (i == WIDTH - 1) begin : g_hi_edge
            assign hi_c[i] = ser_in;
        end else begin : g_hi_mid
            assign hi_c[i] = q[i+1];
        end

        multimode_ff_cell #(
            .RST_BIT (RST_VAL[i])
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .mode       (mode),
            .a          (a[i]),
            .b          (b[i]),
            .lo_in      (lo_c[i]),
            .hi_in      (hi_c[i]),
            .next_c     (next_c[i]),
            .conflict_c (conflict_c[i]),
            .q          (q[i]),
            .conflict   (sr_conflict[i])
        );
    end

    // Serial output captures the bit falling off the end; holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            ser_out <= 1'b0;
        end else if (en && mode == MODE_SHL) begin
            ser_out <= q[WIDTH-1];
        end else if (en && mode == MODE_SHR) begin
            ser_out <= q[0];
        end
    end

    // Sticky error: a new conflict outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_err <= 1'b0;
        end else if (|conflict_c) begin
            sr_err <= 1'b1;
        end else if (clr_err) begin
            sr_err <= 1'b0;
        end
    end

endmodule
